uart_slot_sequencer: RTL and testbench

- Bus-master controller that drives the uart_core slot interface (cs/read/write/reg_addr/wr_data/rd_data).
- Three jobs: applies baud/data-width configuration, arbitrates two TX byte requesters round-robin, and drains the RX FIFO into a valid/ready output stream.
- Sits between processor-side/user logic and a single uart_core instance, replacing direct software slot access.

---
 rtl/uart_slot_sequencer.sv | 144 ++++++++++++++
 tb/tb_uart_slot_sequencer.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_slot_sequencer.sv
// Bus master for the uart_core slot interface: applies configuration, arbitrates
// two TX byte requesters round-robin and drains the RX FIFO into a valid/ready stream.
module uart_slot_sequencer #(
    parameter int DVSR_WIDTH = 11,
    parameter int DATA_BITS  = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cfg_valid,
    input  logic [DVSR_WIDTH-1:0] cfg_dvsr,
    input  logic                  cfg_data7,
    output logic                  cfg_ready,
    input  logic                  tx0_valid,
    input  logic [DATA_BITS-1:0]  tx0_data,
    output logic                  tx0_ready,
    input  logic                  tx1_valid,
    input  logic [DATA_BITS-1:0]  tx1_data,
    output logic                  tx1_ready,
    output logic                  rx_valid,
    output logic [DATA_BITS-1:0]  rx_data,
    input  logic                  rx_ready,
    output logic                  uart_cs,
    output logic                  uart_read,
    output logic                  uart_write,
    output logic [4:0]            uart_reg_addr,
    output logic [31:0]           uart_wr_data,
    input  logic [31:0]           uart_rd_data,
    input  logic                  uart_tx_full,
    input  logic                  uart_rx_empty,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, GAP} state_t;
    typedef enum logic [1:0] {OP_NONE, OP_CTRL, OP_READ, OP_WRITE} op_t;

    localparam logic [4:0] ADDR_CTRL  = 5'd0;
    localparam logic [4:0] ADDR_READ  = 5'd2;
    localparam logic [4:0] ADDR_WRITE = 5'd3;

    state_t               state, state_nx;
    op_t                  op_q, op_sel;
    logic                 grant_sel;
    logic                 last_grant;
    logic                 data7_q;
    logic [31:0]          ctrl_word;
    logic [31:0]          tx_word;
    logic [DATA_BITS-1:0] rd_byte;
    logic                 unused_rd_bits;

    assign unused_rd_bits = ^uart_rd_data[31:DATA_BITS];

    // IDLE decision: config, then RX drain, then TX round-robin
    always_comb begin
        op_sel    = OP_NONE;
        grant_sel = 1'b0;
        if (state == IDLE) begin
            if (cfg_valid) begin
                op_sel = OP_CTRL;
            end else if (!uart_rx_empty && !rx_valid) begin
                op_sel = OP_READ;
            end else if ((tx0_valid || tx1_valid) && !uart_tx_full) begin
                op_sel = OP_WRITE;
                if (tx0_valid && tx1_valid) grant_sel = ~last_grant;
                else                        grant_sel = tx1_valid;
            end
        end
    end

    always_comb begin
        ctrl_word                   = '0;
        ctrl_word[DVSR_WIDTH-1:0]   = cfg_dvsr;
        ctrl_word[15]               = cfg_data7;
        tx_word                     = '0;
        tx_word[DATA_BITS-1:0]      = grant_sel ? tx1_data : tx0_data;
        rd_byte                     = uart_rd_data[DATA_BITS-1:0];
        if (data7_q) rd_byte[7]     = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (op_sel != OP_NONE) state_nx = ACCESS;
            ACCESS:  state_nx = GAP;
            GAP:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != IDLE);
        cfg_ready  = (state == IDLE);
        tx0_ready  = (op_sel == OP_WRITE) && !grant_sel;
        tx1_ready  = (op_sel == OP_WRITE) && grant_sel;
        uart_cs    = (state == ACCESS);
        uart_write = (state == ACCESS) && ((op_q == OP_CTRL) || (op_q == OP_WRITE));
        uart_read  = (state == ACCESS) && (op_q == OP_READ);
    end

    // Slot address/data are latched at the IDLE decision and held between accesses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q          <= OP_NONE;
            uart_reg_addr <= '0;
            uart_wr_data  <= '0;
            last_grant    <= 1'b1;
            data7_q       <= 1'b0;
            rx_valid      <= 1'b0;
            rx_data       <= '0;
        end else begin
            case (op_sel)
                OP_CTRL: begin
                    op_q          <= OP_CTRL;
                    uart_reg_addr <= ADDR_CTRL;
                    uart_wr_data  <= ctrl_word;
                    data7_q       <= cfg_data7;
                end
                OP_READ: begin
                    op_q          <= OP_READ;
                    uart_reg_addr <= ADDR_READ;
                end
                OP_WRITE: begin
                    op_q          <= OP_WRITE;
                    uart_reg_addr <= ADDR_WRITE;
                    uart_wr_data  <= tx_word;
                    last_grant    <= grant_sel;
                end
                default: ;
            endcase

            if (state == ACCESS && op_q == OP_READ) begin
                rx_valid <= 1'b1;
                rx_data  <= rd_byte;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_slot_sequencer.sv
// Scoreboard bench for uart_slot_sequencer: stimulus pushes expected slot
// transactions and RX bytes; monitors pop and compare against what the DUT presents.
module tb_uart_slot_sequencer;

    localparam int DW = 11;
    localparam int DB = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cfg_valid = 1'b0;
    logic [DW-1:0] cfg_dvsr = '0;
    logic          cfg_data7 = 1'b0;
    logic          cfg_ready;
    logic          tx0_valid = 1'b0;
    logic [DB-1:0] tx0_data = '0;
    logic          tx0_ready;
    logic          tx1_valid = 1'b0;
    logic [DB-1:0] tx1_data = '0;
    logic          tx1_ready;
    logic          rx_valid;
    logic [DB-1:0] rx_data;
    logic          rx_ready = 1'b0;
    logic          uart_cs, uart_read, uart_write;
    logic [4:0]    uart_reg_addr;
    logic [31:0]   uart_wr_data;
    logic [31:0]   uart_rd_data = '0;
    logic          uart_tx_full = 1'b0;
    logic          uart_rx_empty = 1'b1;
    logic          busy;

    always #5 clk = ~clk;

    uart_slot_sequencer #(.DVSR_WIDTH(DW), .DATA_BITS(DB)) dut (
        .clk(clk), .reset_n(reset_n),
        .cfg_valid(cfg_valid), .cfg_dvsr(cfg_dvsr), .cfg_data7(cfg_data7), .cfg_ready(cfg_ready),
        .tx0_valid(tx0_valid), .tx0_data(tx0_data), .tx0_ready(tx0_ready),
        .tx1_valid(tx1_valid), .tx1_data(tx1_data), .tx1_ready(tx1_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .uart_cs(uart_cs), .uart_read(uart_read), .uart_write(uart_write),
        .uart_reg_addr(uart_reg_addr), .uart_wr_data(uart_wr_data), .uart_rd_data(uart_rd_data),
        .uart_tx_full(uart_tx_full), .uart_rx_empty(uart_rx_empty), .busy(busy)
    );

    typedef struct {
        logic        is_read;
        logic [4:0]  addr;
        logic [31:0] data;
    } slot_t;

    slot_t      slot_exp[$];
    logic [7:0] rx_exp[$];
    logic [7:0] fifo[$];
    logic [7:0] fifo_pop;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    logic m_last = 1'b1;
    logic m_d7 = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // Behavioural core RX FIFO
    always @(posedge clk) if (uart_cs && uart_read && fifo.size() > 0) fifo_pop = fifo.pop_front();
    always @(negedge clk) begin
        uart_rx_empty = (fifo.size() == 0);
        uart_rd_data  = (fifo.size() > 0) ? {24'h0, fifo[0]} : 32'h0;
    end

    // Slot monitor
    always @(negedge clk) begin
        if (uart_cs) begin
            if (slot_exp.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_slot: actual read=%0b write=%0b addr=%0d data=0x%0h required=none",
                         uart_read, uart_write, uart_reg_addr, uart_wr_data);
            end else begin
                slot_t e;
                e = slot_exp.pop_front();
                check("slot_read", uart_read, e.is_read);
                check("slot_write", uart_write, !e.is_read);
                check("slot_addr", uart_reg_addr, e.addr);
                if (!e.is_read) check("slot_wdata", uart_wr_data, e.data);
            end
        end else begin
            check("strobes_without_cs", {uart_read, uart_write}, 0);
        end
    end

    // RX stream monitor: handshake completes at the next posedge
    always begin
        @(negedge clk); #3;
        if (reset_n && rx_valid && rx_ready) begin
            if (rx_exp.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_rx: actual=0x%0h required=none", rx_data);
            end else begin
                check("rx_data", rx_data, rx_exp.pop_front());
            end
        end
    end

    task automatic drive_wait();
        @(negedge clk); #2;
    endtask

    function automatic slot_t mk_write(input logic [4:0] a, input logic [31:0] d);
        slot_t s;
        s.is_read = 1'b0; s.addr = a; s.data = d;
        return s;
    endfunction

    function automatic slot_t mk_read();
        slot_t s;
        s.is_read = 1'b1; s.addr = 5'd2; s.data = 32'h0;
        return s;
    endfunction

    function automatic logic [7:0] rx_mask(input logic [7:0] b);
        return m_d7 ? (b & 8'h7F) : b;
    endfunction

    task automatic send_cfg(input logic [DW-1:0] dv, input logic d7);
        int n = 0;
        drive_wait();
        cfg_valid = 1'b1; cfg_dvsr = dv; cfg_data7 = d7;
        #1;
        while (!cfg_ready && n < 20) begin drive_wait(); #1; n++; end
        check("cfg_handshake", cfg_ready, 1);
        if (cfg_ready) begin
            slot_exp.push_back(mk_write(5'd0, {16'h0, d7, 4'h0, dv}));
            m_d7 = d7;
        end
        drive_wait();
        cfg_valid = 1'b0;
    endtask

    // Entered at a drive point; returns sampled one step later
    task automatic wait_grant(output logic ok, output int n);
        n = 0;
        #1;
        while (!(tx0_ready || tx1_ready) && n < 12) begin drive_wait(); #1; n++; end
        ok = tx0_ready || tx1_ready;
        check("grant_timeout", ok, 1);
    endtask

    task automatic send_tx_single(input logic who, input logic [7:0] d);
        logic ok; int n;
        drive_wait();
        if (who) begin tx1_valid = 1'b1; tx1_data = d; end
        else     begin tx0_valid = 1'b1; tx0_data = d; end
        wait_grant(ok, n);
        if (ok) begin
            check("single_grant", tx1_ready, who);
            slot_exp.push_back(mk_write(5'd3, {24'h0, d}));
            m_last = who;
        end
        drive_wait();
        tx0_valid = 1'b0; tx1_valid = 1'b0;
    endtask

    task automatic round_robin(input int count, input logic fresh_data);
        logic ok; int n; int prev; logic g;
        prev = 0;
        drive_wait();
        tx0_valid = 1'b1; tx1_valid = 1'b1;
        for (int k = 0; k < count; k++) begin
            wait_grant(ok, n);
            if (!ok) break;
            check("rr_grant", {tx1_ready, tx0_ready}, m_last ? 2'b01 : 2'b10);
            g = tx1_ready;
            slot_exp.push_back(mk_write(5'd3, {24'h0, g ? tx1_data : tx0_data}));
            m_last = g;
            if (k > 0) check("rr_spacing", cyc - prev, 3);
            prev = cyc;
            drive_wait();
            if (fresh_data) begin
                if (g) tx1_data = 8'($urandom);
                else   tx0_data = 8'($urandom);
            end
        end
        tx0_valid = 1'b0; tx1_valid = 1'b0;
    endtask

    task automatic wait_rx_drain(input int budget, input logic random_ready);
        int n = 0;
        while (rx_exp.size() > 0 && n < budget) begin
            drive_wait();
            if (random_ready) rx_ready = 1'(($urandom_range(0, 3) != 0));
            n++;
        end
        check("rx_drain", rx_exp.size(), 0);
        drive_wait();
        rx_ready = 1'b1;
        repeat (4) drive_wait();
    endtask

    initial begin
        logic ok; int n; logic [7:0] b; logic [DW-1:0] dv; logic d7;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("reset_cs", uart_cs, 0);
        check("reset_rx_valid", rx_valid, 0);
        drive_wait();
        reset_n = 1'b1;
        #1;
        check("reset_cfg_ready", cfg_ready, 1);
        check("reset_busy", busy, 0);
        check("reset_tx_ready", {tx0_ready, tx1_ready}, 0);
        check("reset_addr", uart_reg_addr, 0);
        check("reset_wdata", uart_wr_data, 0);
        check("reset_rx_data", rx_data, 0);

        // Configuration
        send_cfg(11'd650, 1'b1);
        send_cfg(11'd650, 1'b0);
        repeat (3) send_cfg(11'($urandom), 1'($urandom));
        send_cfg(11'd650, 1'b0);
        repeat (3) drive_wait();

        // Round-robin, fixed then random bytes
        tx0_data = 8'h11; tx1_data = 8'h22;
        round_robin(4, 1'b0);
        repeat (3) drive_wait();
        round_robin(int'($urandom_range(6, 12)), 1'b1);
        repeat (3) drive_wait();
        send_tx_single(1'b1, 8'($urandom));
        send_tx_single(1'b1, 8'($urandom));
        repeat (3) drive_wait();

        // TX back-pressure
        drive_wait();
        uart_tx_full = 1'b1; tx0_valid = 1'b1; tx0_data = 8'($urandom);
        for (int i = 0; i < 10; i++) begin
            #1; check("bp_tx0_ready", tx0_ready, 0);
            drive_wait();
        end
        uart_tx_full = 1'b0;
        wait_grant(ok, n);
        check("bp_release_latency_ok", n <= 2, 1);
        if (ok) begin
            check("bp_grant", tx0_ready, 1);
            slot_exp.push_back(mk_write(5'd3, {24'h0, tx0_data}));
            m_last = 1'b0;
        end
        drive_wait();
        tx0_valid = 1'b0;
        repeat (3) drive_wait();

        // RX drain with back-pressure
        rx_ready = 1'b0;
        fifo.push_back(8'hA5); fifo.push_back(8'h3C);
        slot_exp.push_back(mk_read());
        rx_exp.push_back(rx_mask(8'hA5));
        n = 0;
        drive_wait(); #1;
        while (!rx_valid && n < 20) begin drive_wait(); #1; n++; end
        check("rx_valid_up", rx_valid, 1);
        for (int i = 0; i < 12; i++) begin
            drive_wait(); #1;
            check("rx_hold_valid", rx_valid, 1);
            check("rx_hold_data", rx_data, 8'hA5);
        end
        slot_exp.push_back(mk_read());
        rx_exp.push_back(rx_mask(8'h3C));
        drive_wait();
        rx_ready = 1'b1;
        wait_rx_drain(40, 1'b0);

        // 7-bit mode masks bit 7
        send_cfg(11'($urandom), 1'b1);
        fifo.push_back(8'hC1);
        slot_exp.push_back(mk_read());
        rx_exp.push_back(8'h41);
        wait_rx_drain(40, 1'b0);

        // Random RX bursts in both modes with random consumer stalls
        for (int r = 0; r < 2; r++) begin
            send_cfg(11'($urandom), 1'(r));
            for (int i = 0; i < 8; i++) begin
                b = 8'($urandom);
                fifo.push_back(b);
                slot_exp.push_back(mk_read());
                rx_exp.push_back(rx_mask(b));
            end
            wait_rx_drain(400, 1'b1);
        end

        // Priority: cfg, pending RX and tx0 in the same IDLE cycle
        b = 8'($urandom); dv = 11'($urandom); d7 = 1'($urandom);
        fifo.push_back(b);
        drive_wait();
        cfg_valid = 1'b1; cfg_dvsr = dv; cfg_data7 = d7;
        tx0_valid = 1'b1; tx0_data = 8'($urandom);
        slot_exp.push_back(mk_write(5'd0, {16'h0, d7, 4'h0, dv}));
        slot_exp.push_back(mk_read());
        slot_exp.push_back(mk_write(5'd3, {24'h0, tx0_data}));
        m_d7 = d7;
        rx_exp.push_back(rx_mask(b));
        #1;
        check("prio_cfg_ready", cfg_ready, 1);
        check("prio_tx0_ready", tx0_ready, 0);
        drive_wait();
        cfg_valid = 1'b0;
        wait_grant(ok, n);
        drive_wait();
        tx0_valid = 1'b0;
        m_last = 1'b0;
        wait_rx_drain(40, 1'b0);

        // Reset during ACCESS with a buffered RX byte
        rx_ready = 1'b0;
        fifo.push_back(8'h5A);
        slot_exp.push_back(mk_read());
        n = 0;
        drive_wait(); #1;
        while (!rx_valid && n < 20) begin drive_wait(); #1; n++; end
        check("pre_reset_rx_valid", rx_valid, 1);
        drive_wait();
        cfg_valid = 1'b1; cfg_dvsr = 11'($urandom); cfg_data7 = 1'b1;
        #1;
        check("pre_reset_cfg_ready", cfg_ready, 1);
        slot_exp.push_back(mk_write(5'd0, {16'h0, 1'b1, 4'h0, cfg_dvsr}));
        drive_wait();
        cfg_valid = 1'b0;
        check("pre_reset_cs", uart_cs, 1);
        reset_n = 1'b0;
        #1;
        check("rst_cs", uart_cs, 0);
        check("rst_strobes", {uart_read, uart_write}, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_cfg_ready", cfg_ready, 1);
        check("rst_slot_queue", slot_exp.size(), 0);
        rx_exp.delete();
        slot_exp.delete();
        m_last = 1'b1; m_d7 = 1'b0;
        repeat (2) drive_wait();
        reset_n = 1'b1;
        #1;
        check("post_rst_cfg_ready", cfg_ready, 1);
        rx_ready = 1'b1;
        tx0_data = 8'($urandom); tx1_data = 8'($urandom);
        round_robin(3, 1'b1);
        repeat (4) drive_wait();

        check("end_slot_queue", slot_exp.size(), 0);
        check("end_rx_queue", rx_exp.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
